// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop rx synchronizer, mid-bit sampling FSM, valid/ready word output.
// Define UART_RX_FIFO_EN for a 4-entry FWFT word FIFO; otherwise a single holding register.
module uart_rx_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  rx,
    input  logic                  rx_ready,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int                CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     HALF      = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]     FULL      = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_DATA = 3'(DATA_WIDTH - 1);
    localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
    localparam int                WORD_W    = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and falling-edge detect (idle-high line resets to 1)
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, prev_q;
    logic fall;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [2:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  commit_q;
    logic                  bit_tick;

    assign bit_tick = (cnt_q == FULL);
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    // A line that is high again at mid-start was a glitch.
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        state_q <= sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                            state_q   <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        perr_q  <= ((^shift_q) ^ sync2_q) != PARITY_ODD;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (!sync2_q) begin
                            ferr_q <= 1'b1;
                        end
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            commit_q  <= 1'b1;
                            // A low stop bit may be a break: wait for the line to recover.
                            state_q   <= sync2_q ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word storage
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] commit_word;
    logic [WORD_W-1:0] head;
    logic              pop;
    logic              ovr_d;
    logic              overrun_q;

    assign commit_word = {ferr_q, perr_q, shift_q};
    assign pop         = rx_valid & rx_ready;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic              push;
    logic              full;

    assign full = (count_q == 3'(DEPTH));

    // A pop on the commit cycle frees the slot, so the commit is never dropped then.
    always_comb begin
        push     = commit_q & (~full | pop);
        ovr_d    = commit_q & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the word array has no reset; outputs are gated by rx_valid, so stale entries never show.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= commit_word;
        end
    end

    assign rx_valid = (count_q != 3'd0);
    assign head     = mem_q[rd_ptr_q];
`else
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (commit_q) begin
            if (valid_q && !pop) begin
                ovr_d = 1'b1;
            end else begin
                hold_d  = commit_word;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_valid = valid_q;
    assign head     = hold_q;
`endif

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= ovr_d;
        end
    end

    assign overrun                          = overrun_q;
    assign {frame_err, parity_err, rx_data} = rx_valid ? head : '0;

    // Held word must not change or vanish until it is accepted.
    hold_stable: assert property (@(posedge pclk) disable iff (!areset)
        (rx_valid && !rx_ready) |=> (rx_valid && $stable(rx_data)));

endmodule
